// File: rtl/serial_pkg.sv
// Shared types and line-level constants for the serial receiver.
// Pure declarations: no latency, no flow control.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } rx_state_t;

  localparam int DATA_BITS = 8;
  localparam int CNT_W     = $clog2(DATA_BITS);

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Bit counter value carried by the final data-bit strobe of a frame.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

endpackage

// File: rtl/rx_shift_reg.sv
// Serial-in shift register with per-frame direction; one bit per enabled cycle.
// Latency: one clock per shift. No backpressure: en is the only qualifier.
module rx_shift_reg
  import serial_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 msb_first,
  input  logic                 din,
  output logic [DATA_BITS-1:0] dout
);

  // msb_first: new bit enters at bit 0 so the first bit ends up at the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (en) begin
      if (msb_first) begin
        dout <= {dout[DATA_BITS-2:0], din};
      end else begin
        dout <= {din, dout[DATA_BITS-1:1]};
      end
    end
  end

endmodule

// File: rtl/serial_receiver.sv
// Strobed 8N1 serial receiver with single-byte holding register and sticky errors.
// Byte visible the cycle after the stop strobe; no backpressure, late ack flags overrun.
module serial_receiver
  import serial_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin,
  input  logic                 sin_en,
  input  logic                 msb_first,
  input  logic                 q_ack,
  output logic [DATA_BITS-1:0] q,
  output logic                 q_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  rx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  dir_q, dir_d;
  logic                  wait_q, wait_d;
  logic                  shift_en;
  logic                  deliver;
  logic                  bad_stop;
  logic [DATA_BITS-1:0]  shift_dat;

  rx_shift_reg u_shift (
    .clk       (clk),
    .rst       (rst),
    .en        (shift_en),
    .msb_first (dir_q),
    .din       (sin),
    .dout      (shift_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      wait_q  <= wait_d;
    end
  end

  // wait_q blocks a new start after a bad stop until the line is seen idle again.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    wait_d   = wait_q;
    shift_en = 1'b0;
    deliver  = 1'b0;
    bad_stop = 1'b0;
    if (sin_en) begin
      case (state_q)
        IDLE: begin
          if (sin == START_LVL && !wait_q) begin
            state_d = DATA;
            cnt_d   = '0;
            dir_d   = msb_first;
          end else if (sin == IDLE_LVL) begin
            wait_d = 1'b0;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_d = STOP;
          end
        end
        STOP: begin
          state_d = IDLE;
          if (sin == STOP_LVL) begin
            deliver = 1'b1;
          end else begin
            bad_stop = 1'b1;
            wait_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q         <= '0;
      q_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (deliver) begin
        q         <= shift_dat;
        q_valid   <= 1'b1;
        frame_err <= 1'b0;
        // An ack in the same cycle consumes the old byte, so nothing is lost.
        if (q_valid && !q_ack) begin
          overrun <= 1'b1;
        end
      end else if (q_ack) begin
        q_valid <= 1'b0;
      end
      if (bad_stop) begin
        frame_err <= 1'b1;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_serial_receiver.sv
// Randomized and directed bench for serial_receiver against a frame-level reference model.
module tb_serial_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sin = 1'b1;
  logic       sin_en = 1'b0;
  logic       msb_first = 1'b1;
  logic       q_ack = 1'b0;
  logic [7:0] q;
  logic       q_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit         m_busy, m_dir, m_wait, m_valid, m_ferr, m_ovr;
  logic [7:0] m_q;
  bit         m_bits[$];
  bit         rnd_mode = 1'b0;

  serial_receiver dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_en    (sin_en),
    .msb_first (msb_first),
    .q_ack     (q_ack),
    .q         (q),
    .q_valid   (q_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame-level model: collect the 9 bits after a start bit, then assemble the byte.
  task automatic model_step(input bit r, input bit en, input bit s, input bit a, input bit m);
    bit         deliver;
    logic [7:0] b;
    deliver = 1'b0;
    if (r) begin
      m_busy = 0; m_dir = 0; m_wait = 0; m_valid = 0; m_ferr = 0; m_ovr = 0;
      m_q = 8'h00;
      m_bits.delete();
      return;
    end
    if (en) begin
      if (!m_busy) begin
        if (s == 1'b0 && !m_wait) begin
          m_busy = 1;
          m_dir  = m;
          m_bits.delete();
        end else if (s == 1'b1) begin
          m_wait = 0;
        end
      end else begin
        m_bits.push_back(s);
        if (m_bits.size() == 9) begin
          b = 8'h00;
          for (int i = 0; i < 8; i++) begin
            if (m_dir) b[7-i] = m_bits[i];
            else       b[i]   = m_bits[i];
          end
          m_busy = 0;
          if (m_bits[8]) begin
            deliver = 1'b1;
            if (m_valid && !a) m_ovr = 1;
            m_q     = b;
            m_valid = 1;
            m_ferr  = 0;
          end else begin
            m_ferr = 1;
            m_wait = 1;
          end
        end
      end
    end
    if (!deliver && a) m_valid = 0;
  endtask

  task automatic step(input bit r, input bit en, input bit s, input bit a);
    rst = r; sin_en = en; sin = s; q_ack = a;
    model_step(r, en, s, a, msb_first);
    @(posedge clk);
    #1;
    check_eq("q", q, m_q);
    check_eq("q_valid", 8'(q_valid), 8'(m_valid));
    check_eq("frame_err", 8'(frame_err), 8'(m_ferr));
    check_eq("overrun", 8'(overrun), 8'(m_ovr));
    check_eq("busy", 8'(busy), 8'(m_busy));
  endtask

  function automatic bit rnd_ack();
    return rnd_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
  endfunction

  task automatic strobe(input bit s);
    step(1'b0, 1'b1, s, rnd_ack());
  endtask

  task automatic gap(input int max_gap);
    int n;
    n = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom), rnd_ack());
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop, input bit dir,
                            input int max_gap, input bit ack_stop);
    msb_first = dir;
    gap(max_gap);
    strobe(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (rnd_mode) msb_first = 1'($urandom);
      gap(max_gap);
      strobe(dir ? b[7-i] : b[i]);
    end
    gap(max_gap);
    step(1'b0, 1'b1, stop, ack_stop | rnd_ack());
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] v_bits;

    // reset state
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("rst_q", q, 8'h00);
    check_eq("rst_q_valid", 8'(q_valid), 8'h00);
    check_eq("rst_frame_err", 8'(frame_err), 8'h00);
    check_eq("rst_overrun", 8'(overrun), 8'h00);
    check_eq("rst_busy", 8'(busy), 8'h00);

    // V1: msb first
    v_bits = 8'b1010_0101;
    msb_first = 1'b1;
    strobe(1'b0);
    check_eq("v1_busy", 8'(busy), 8'h01);
    for (int i = 0; i < 8; i++) strobe(v_bits[7-i]);
    check_eq("v1_early_valid", 8'(q_valid), 8'h00);
    strobe(1'b1);
    check_eq("v1_q", q, 8'hA5);
    check_eq("v1_q_valid", 8'(q_valid), 8'h01);
    check_eq("v1_frame_err", 8'(frame_err), 8'h00);
    check_eq("v1_busy_done", 8'(busy), 8'h00);

    // V2: same bit stream, lsb first
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("v2_ack", 8'(q_valid), 8'h00);
    msb_first = 1'b0;
    strobe(1'b0);
    for (int i = 0; i < 8; i++) strobe(v_bits[7-i]);
    strobe(1'b1);
    check_eq("v2_q", q, 8'hA5);
    check_eq("v2_q_valid", 8'(q_valid), 8'h01);

    // V3: bad stop bit, then a good frame
    send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);
    check_eq("v3_frame_err", 8'(frame_err), 8'h01);
    check_eq("v3_q_kept", q, 8'hA5);
    check_eq("v3_q_valid_kept", 8'(q_valid), 8'h01);
    strobe(1'b0);
    check_eq("v3_no_restart", 8'(busy), 8'h00);
    strobe(1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h11, 1'b1, 1'b1, 0, 1'b0);
    check_eq("v3_q", q, 8'h11);
    check_eq("v3_frame_err_clr", 8'(frame_err), 8'h00);

    // V4: overrun without ack, none with ack on the delivery cycle
    do_reset();
    send_frame(8'h01, 1'b1, 1'b1, 0, 1'b0);
    send_frame(8'h02, 1'b1, 1'b1, 0, 1'b0);
    check_eq("v4_q", q, 8'h02);
    check_eq("v4_overrun", 8'(overrun), 8'h01);
    do_reset();
    send_frame(8'h01, 1'b1, 1'b1, 0, 1'b0);
    send_frame(8'h02, 1'b1, 1'b1, 0, 1'b1);
    check_eq("v4a_q", q, 8'h02);
    check_eq("v4a_q_valid", 8'(q_valid), 8'h01);
    check_eq("v4a_overrun", 8'(overrun), 8'h00);

    // V5: reset after four data bits
    msb_first = 1'b1;
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("v5_q", q, 8'h00);
    check_eq("v5_q_valid", 8'(q_valid), 8'h00);
    check_eq("v5_overrun", 8'(overrun), 8'h00);
    check_eq("v5_busy", 8'(busy), 8'h00);
    send_frame(8'hFF, 1'b1, 1'b0, 0, 1'b0);
    check_eq("v5_q_ff", q, 8'hFF);

    // V6: strobes paused mid-frame while the line toggles
    step(1'b0, 1'b0, 1'b1, 1'b1);
    v_bits = 8'h6B;
    msb_first = 1'b1;
    strobe(1'b0);
    for (int i = 0; i < 3; i++) strobe(v_bits[7-i]);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'(i), 1'b0);
      check_eq("v6_hold_busy", 8'(busy), 8'h01);
    end
    for (int i = 3; i < 8; i++) strobe(v_bits[7-i]);
    strobe(1'b1);
    check_eq("v6_q", q, 8'h6B);
    check_eq("v6_q_valid", 8'(q_valid), 8'h01);

    // randomized frames with gaps, random acks, direction churn, bad stops
    rnd_mode = 1'b1;
    for (int n = 0; n < 200; n++) begin
      strobe(1'b1);
      send_frame(8'($urandom), ($urandom_range(0, 7) != 0), 1'($urandom), 3, 1'b0);
      if ($urandom_range(0, 39) == 0) do_reset();
    end

    // fully random line activity, including spurious starts and rare resets
    for (int n = 0; n < 3000; n++) begin
      msb_first = 1'($urandom);
      step(($urandom_range(0, 299) == 0), 1'($urandom), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
